result_pack_fifo: RTL and testbench

- Second-generation result collector for one systolic-array output lane group.
- Accepts up to ARRAY_WIDTH result elements per cycle, in any combination of lanes.
- Packs them in order into BUS_WIDTH words and buffers the words in a DEPTH-entry FIFO.
- Presents the words on a valid/ready bus port; supports explicit flush of partial words and sticky overflow reporting.

---
 rtl/result_pack_fifo_pkg.sv | 30 +++
 rtl/result_pack_fifo_word_fifo.sv | 54 +++++
 rtl/result_pack_fifo.sv | 143 ++++++++++++++
 tb/tb_result_pack_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_pack_fifo_pkg.sv
// Shared types and helpers for the result packer: slot math, popcount and the FIFO entry.
// The entry struct is sized from the package widths; the top-level defaults follow them.
package result_pack_pkg;

    localparam int PKG_DATA_W = 16;
    localparam int PKG_BUS_W  = 256;

    function automatic int slot_count(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    localparam int PKG_SLOTS  = slot_count(PKG_BUS_W, PKG_DATA_W);
    localparam int SLOT_CNT_W = $clog2(PKG_SLOTS + 1);

    function automatic int popcount(input logic [63:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) c += int'(v[i]);
        return c;
    endfunction

    typedef struct packed {
        logic [PKG_BUS_W-1:0]  data;
        logic                  last;
        logic [SLOT_CNT_W-1:0] slots;
    } fifo_entry_t;

    typedef enum logic {ACCUM, FLUSH_PEND} pack_state_e;

endpackage

// File: rtl/result_pack_fifo_word_fifo.sv
// Synchronous word FIFO with a separate occupancy count; a pop frees room for a same-cycle push.
module result_word_fifo
    import result_pack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  fifo_entry_t                entry_i,
    input  logic                       pop_i,
    output fifo_entry_t                entry_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    fifo_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign entry_o = mem_q[rd_ptr_q];
    assign level_o = count_q;

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/result_pack_fifo.sv
// Packs per-lane array results in order into bus words, buffers them, and handles flush/overflow.
// Changing DATA_WIDTH or BUS_WIDTH also requires the matching widths in result_pack_pkg.
module result_pack_fifo
    import result_pack_pkg::*;
#(
    parameter int ARRAY_WIDTH = 4,
    parameter int DATA_WIDTH  = PKG_DATA_W,
    parameter int BUS_WIDTH   = PKG_BUS_W,
    parameter int DEPTH       = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [ARRAY_WIDTH-1:0]                   res_valid_i,
    input  logic [ARRAY_WIDTH*DATA_WIDTH-1:0]        res_data_i,
    input  logic                                     flush_i,
    output logic [BUS_WIDTH-1:0]                     data_o,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic                                     last_o,
    output logic [$clog2(BUS_WIDTH/DATA_WIDTH+1)-1:0] slots_o,
    output logic [$clog2(DEPTH+1)-1:0]               level_o,
    output logic                                     overflow_o,
    input  logic                                     clear_overflow_i
);

    localparam int SLOTS  = slot_count(BUS_WIDTH, DATA_WIDTH);
    localparam int FILL_W = $clog2(SLOTS);
    localparam int TOT_W  = $clog2(2 * SLOTS);

    pack_state_e                         state_q, state_d;
    logic [SLOTS-1:0][DATA_WIDTH-1:0]    asm_q, asm_d;
    logic [FILL_W-1:0]                   fill_q, fill_d;
    logic                                overflow_q;

    logic [2*SLOTS-1:0][DATA_WIDTH-1:0]  ext_c;
    logic [TOT_W-1:0]                    idx_c, total_c;
    logic                                push_c, push_last_c;
    logic [SLOT_CNT_W-1:0]               push_slots_c;
    fifo_entry_t                         push_entry, head_entry;
    logic                                fifo_full, fifo_empty, pop_c, drop_c;

    // Existing partial word sits in the low slots; this cycle's valid lanes are appended after it.
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        ext_c            = '0;
        ext_c[SLOTS-1:0] = asm_q;
        idx_c            = TOT_W'(fill_q);
        for (int i = 0; i < ARRAY_WIDTH; i++) begin
            if (res_valid_i[i]) begin
                ext_c[idx_c] = res_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                idx_c        = idx_c + 1'b1;
            end
        end
        total_c = TOT_W'(fill_q) + TOT_W'(popcount(64'(res_valid_i)));
    end

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        fill_d       = fill_q;
        push_c       = 1'b0;
        push_last_c  = 1'b0;
        push_slots_c = SLOT_CNT_W'(SLOTS);
        unique case (state_q)
            ACCUM: begin
                if (total_c >= TOT_W'(SLOTS)) begin
                    push_c = 1'b1;
                    asm_d  = ext_c[2*SLOTS-1:SLOTS];
                    fill_d = FILL_W'(total_c - TOT_W'(SLOTS));
                    if (flush_i) begin
                        if (total_c == TOT_W'(SLOTS)) push_last_c = 1'b1;
                        else                          state_d     = FLUSH_PEND;
                    end
                end else if (flush_i && total_c != '0) begin
                    push_c       = 1'b1;
                    push_last_c  = 1'b1;
                    push_slots_c = SLOT_CNT_W'(total_c);
                    asm_d        = '0;
                    fill_d       = '0;
                end else begin
                    asm_d  = ext_c[SLOTS-1:0];
                    fill_d = FILL_W'(total_c);
                end
            end
            FLUSH_PEND: begin
                // A flush request arriving here is absorbed by the one already in progress.
                if (total_c > TOT_W'(SLOTS)) begin
                    push_c = 1'b1;
                    asm_d  = ext_c[2*SLOTS-1:SLOTS];
                    fill_d = FILL_W'(total_c - TOT_W'(SLOTS));
                end else begin
                    state_d = ACCUM;
                    asm_d   = '0;
                    fill_d  = '0;
                    if (total_c != '0) begin
                        push_c       = 1'b1;
                        push_last_c  = 1'b1;
                        push_slots_c = SLOT_CNT_W'(total_c);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign push_entry = '{data: ext_c[SLOTS-1:0], last: push_last_c, slots: push_slots_c};
    assign pop_c      = valid_o && ready_i;
    assign drop_c     = push_c && fifo_full && !pop_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ACCUM;
            asm_q      <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            fill_q  <= fill_d;
            if (drop_c)                overflow_q <= 1'b1;
            else if (clear_overflow_i) overflow_q <= 1'b0;
        end
    end

    result_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .entry_i (push_entry),
        .pop_i   (pop_c),
        .entry_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign valid_o    = !fifo_empty;
    assign data_o     = valid_o ? head_entry.data  : '0;
    assign last_o     = valid_o ? head_entry.last  : 1'b0;
    assign slots_o    = valid_o ? head_entry.slots : '0;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_result_pack_fifo.sv
// Directed bench for result_pack_fifo: queue-based reference model plus hand-computed literal checks.
module tb_result_pack_fifo;

    localparam int AW = 4, DW = 16, BW = 256, SLOTS = 16, DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   res_valid_i = '0;
    logic [AW*DW-1:0] res_data_i = '0;
    logic            flush_i = 1'b0;
    logic [BW-1:0]   data_o;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic            last_o;
    logic [4:0]      slots_o;
    logic [2:0]      level_o;
    logic            overflow_o;
    logic            clear_overflow_i = 1'b0;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    result_pack_fifo #(.ARRAY_WIDTH(AW), .DATA_WIDTH(DW), .BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .res_valid_i(res_valid_i), .res_data_i(res_data_i),
        .flush_i(flush_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .last_o(last_o), .slots_o(slots_o), .level_o(level_o), .overflow_o(overflow_o),
        .clear_overflow_i(clear_overflow_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a flat element queue and a word queue, stepped on every clock edge.
    typedef struct {
        logic [BW-1:0] data;
        bit            last;
        int            slots;
    } word_t;

    logic [DW-1:0] acc[$];
    word_t         mq[$];
    bit            pend = 1'b0;
    bit            m_ovf = 1'b0;
    bit            drop;

    function automatic void emit(input int n, input bit last);
        word_t w;
        w.data  = '0;
        w.last  = last;
        w.slots = n;
        for (int k = 0; k < n; k++) w.data[k*DW +: DW] = acc.pop_front();
        if (mq.size() < DEPTH) mq.push_back(w);
        else begin
            m_ovf = 1'b1;
            drop  = 1'b1;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc.delete();
            mq.delete();
            pend  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            drop = 1'b0;
            if (ready_i && mq.size() > 0) void'(mq.pop_front());
            for (int i = 0; i < AW; i++)
                if (res_valid_i[i]) acc.push_back(res_data_i[i*DW +: DW]);
            if (pend) begin
                if (acc.size() > SLOTS) emit(SLOTS, 1'b0);
                else begin
                    if (acc.size() > 0) emit(acc.size(), 1'b1);
                    pend = 1'b0;
                end
            end else if (acc.size() >= SLOTS) begin
                emit(SLOTS, flush_i && acc.size() == SLOTS);
                if (flush_i && acc.size() > 0) pend = 1'b1;
            end else if (flush_i && acc.size() > 0) begin
                emit(acc.size(), 1'b1);
            end
            if (!drop && clear_overflow_i) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_valid", valid_o, mq.size() > 0);
            check("cmp_level", level_o, mq.size());
            check("cmp_overflow", overflow_o, m_ovf);
            if (mq.size() > 0) begin
                check("cmp_data", data_o, mq[0].data);
                check("cmp_last", last_o, mq[0].last);
                check("cmp_slots", slots_o, mq[0].slots);
            end
        end
    end

    task automatic cyc(input logic [AW-1:0] v, input logic [AW*DW-1:0] d, input logic fl);
        @(negedge clk);
        res_valid_i = v;
        res_data_i  = d;
        flush_i     = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0, 1'b0);
    endtask

    task automatic singles(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) cyc(4'b0001, {48'h0, 16'(base + DW'(i))}, 1'b0);
    endtask

    task automatic full_words(input int nw);
        for (int w = 0; w < nw; w++)
            for (int c = 0; c < 4; c++)
                cyc(4'hf, {16'(w*256 + 4*c + 3), 16'(w*256 + 4*c + 2),
                           16'(w*256 + 4*c + 1), 16'(w*256 + 4*c)}, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_slots_last", {slots_o, last_o}, 0);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // 1: lane 0 only, 1..16
        ready_i = 1'b1;
        singles(16, 16'd1);
        check("t1_not_early", valid_o, 0);
        idle(1);
        check("t1_valid", valid_o, 1);
        check("t1_data", data_o,
              256'h0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001);
        check("t1_slots", slots_o, 16);
        check("t1_last", last_o, 0);
        idle(2);

        // 2: all lanes, four cycles
        for (int c = 0; c < 4; c++)
            cyc(4'hf, {16'(4*c+3), 16'(4*c+2), 16'(4*c+1), 16'(4*c)}, 1'b0);
        idle(1);
        check("t2_data", data_o,
              256'h000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000);
        idle(1);
        check("t2_one_word", valid_o, 0);

        // 3: straddling word, then flush of the remainder
        singles(14, 16'h0100);
        cyc(4'hf, {16'hD0D0, 16'hC0C0, 16'hB0B0, 16'hA0A0}, 1'b0);
        cyc('0, '0, 1'b1);
        check("t3_w1_slot14", data_o[14*DW +: DW], 16'hA0A0);
        check("t3_w1_slot15", data_o[15*DW +: DW], 16'hB0B0);
        idle(1);
        check("t3_w2_data", data_o, {224'h0, 16'hD0D0, 16'hC0C0});
        check("t3_w2_slots", slots_o, 2);
        check("t3_w2_last", last_o, 1);
        idle(2);

        // 4: flush with overfull total, ready low
        ready_i = 1'b0;
        singles(14, 16'h0200);
        cyc(4'hf, {16'h0303, 16'h0302, 16'h0301, 16'h0300}, 1'b1);
        idle(1);
        check("t4_lvl1", level_o, 1);
        check("t4_w1_last", last_o, 0);
        idle(1);
        check("t4_lvl2", level_o, 2);
        check("t4_w1_stable", data_o[15*DW +: DW], 16'h0301);
        ready_i = 1'b1;
        idle(1);
        check("t4_w2_data", data_o, {224'h0, 16'h0303, 16'h0302});
        check("t4_w2_slots_last", {slots_o, last_o}, {5'd2, 1'b1});
        idle(2);

        // 5: overflow with ready low, clear, drain
        ready_i = 1'b0;
        full_words(5);
        idle(1);
        check("t5_level", level_o, 4);
        check("t5_ovf", overflow_o, 1);
        @(negedge clk);
        clear_overflow_i = 1'b1;
        @(negedge clk);
        clear_overflow_i = 1'b0;
        check("t5_ovf_clr", overflow_o, 0);
        check("t5_head0", data_o[15*DW +: DW], 16'h000f);
        ready_i = 1'b1;
        idle(1);
        check("t5_head1", data_o[15:0], 16'h0100);
        idle(5);
        check("t5_drained", level_o, 0);

        // 6: reset mid-operation
        ready_i = 1'b0;
        full_words(3);
        singles(7, 16'h0400);
        idle(1);
        check("t6_level3", level_o, 3);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_outputs", {valid_o, last_o, slots_o, level_o, overflow_o}, 0);
        check("t6_rst_data", data_o, 0);
        @(negedge clk);
        reset   = 1'b0;
        ready_i = 1'b1;
        singles(16, 16'h0050);
        idle(1);
        check("t6_clean_slot0", data_o[15:0], 16'h0050);
        check("t6_clean_slot15", data_o[15*DW +: DW], 16'h005f);
        check("t6_slots", slots_o, 16);
        idle(3);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
